// File: rtl/conv_data_feeder_pkg.sv
// rtl/conv_data_feeder_pkg.sv - shared widths and FSM encoding for the conv data feeder
package conv_data_feeder_pkg;

    localparam int BIT_WIDTH   = 8;
    localparam int NUM_CHANNEL = 3;
    localparam int NUM_KERNEL  = 4;
    localparam int NUM_WEIGHT  = 9;
    localparam int ADDR_WIDTH  = 12;
    localparam int WADDR_WIDTH = 4;
    localparam int REG_WIDTH   = 32;

    localparam int PIX_WIDTH = BIT_WIDTH * NUM_CHANNEL;
    localparam int WGT_WIDTH = PIX_WIDTH * NUM_KERNEL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_data_feeder.sv
// rtl/conv_data_feeder.sv - loads one 3x3 weight set, then streams pixels to the conv engine on request
module conv_data_feeder
    import conv_data_feeder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_conf_base,
    input  logic [REG_WIDTH-1:0]   i_conf_npix,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_mem_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [PIX_WIDTH-1:0]   i_mem_rdata,
    output logic                   o_wmem_en,
    output logic [WADDR_WIDTH-1:0] o_wmem_addr,
    input  logic [WGT_WIDTH-1:0]   i_wmem_rdata,
    input  logic                   i_data_req,
    output logic [PIX_WIDTH-1:0]   o_data,
    output logic                   o_data_val,
    output logic [WGT_WIDTH-1:0]   o_weight,
    output logic                   o_weight_val
);

    state_t                 state, state_nx;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [REG_WIDTH-1:0]   npix_q;
    logic [REG_WIDTH-1:0]   pcnt;
    logic [WADDR_WIDTH-1:0] wcnt;
    logic                   p_inflight;
    logic                   w_inflight;
    logic [PIX_WIDTH-1:0]   data_hold;
    logic [WGT_WIDTH-1:0]   weight_hold;
    logic                   rd_fire;
    logic                   last_w;
    logic                   last_rd;

    assign last_w  = (wcnt == WADDR_WIDTH'(NUM_WEIGHT - 1));
    assign last_rd = ((pcnt + REG_WIDTH'(1)) == npix_q);

    always_comb begin
        state_nx = state;
        rd_fire  = 1'b0;
        case (state)
            S_IDLE:   if (i_start) state_nx = S_LOAD_W;
            S_LOAD_W: if (last_w) state_nx = (npix_q == '0) ? S_FLUSH : S_STREAM;
            S_STREAM: begin
                rd_fire = i_data_req && (pcnt < npix_q);
                if (rd_fire && last_rd) state_nx = S_FLUSH;
            end
            S_FLUSH:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_wmem_en   = (state == S_LOAD_W);
    assign o_wmem_addr = o_wmem_en ? wcnt : '0;
    assign o_mem_en    = rd_fire;
    assign o_mem_addr  = rd_fire ? (base_q + pcnt[ADDR_WIDTH-1:0]) : '0;

    // Memory data is passed straight through in the return cycle and captured so it holds afterwards.
    assign o_data_val   = p_inflight;
    assign o_data       = p_inflight ? i_mem_rdata : data_hold;
    assign o_weight_val = w_inflight;
    assign o_weight     = w_inflight ? i_wmem_rdata : weight_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            npix_q      <= '0;
            pcnt        <= '0;
            wcnt        <= '0;
            p_inflight  <= 1'b0;
            w_inflight  <= 1'b0;
            data_hold   <= '0;
            weight_hold <= '0;
        end else begin
            state      <= state_nx;
            p_inflight <= rd_fire;
            w_inflight <= o_wmem_en;
            if (p_inflight) data_hold <= i_mem_rdata;
            if (w_inflight) weight_hold <= i_wmem_rdata;
            if (state == S_IDLE && i_start) begin
                base_q <= i_conf_base;
                npix_q <= i_conf_npix;
                pcnt   <= '0;
                wcnt   <= '0;
            end
            if (o_wmem_en) wcnt <= wcnt + WADDR_WIDTH'(1);
            if (rd_fire) pcnt <= pcnt + REG_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_conv_data_feeder.sv
// tb/tb_conv_data_feeder.sv - directed self-checking bench for conv_data_feeder
module tb_conv_data_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [11:0] i_conf_base;
    logic [31:0] i_conf_npix;
    logic        o_busy, o_done, o_mem_en, o_wmem_en;
    logic [11:0] o_mem_addr;
    logic [3:0]  o_wmem_addr;
    logic [23:0] i_mem_rdata;
    logic [95:0] i_wmem_rdata;
    logic        i_data_req;
    logic [23:0] o_data;
    logic        o_data_val;
    logic [95:0] o_weight;
    logic        o_weight_val;

    conv_data_feeder dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_conf_base(i_conf_base),
        .i_conf_npix(i_conf_npix), .o_busy(o_busy), .o_done(o_done),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
        .o_wmem_en(o_wmem_en), .o_wmem_addr(o_wmem_addr), .i_wmem_rdata(i_wmem_rdata),
        .i_data_req(i_data_req), .o_data(o_data), .o_data_val(o_data_val),
        .o_weight(o_weight), .o_weight_val(o_weight_val)
    );

    always #5 clk = ~clk;

    logic [23:0] amem [4096];
    logic [95:0] wmem [16];
    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;
    int req_viol = 0;
    int both_viol = 0;

    int          rd_cyc[$];
    logic [11:0] rd_addr[$];
    int          dv_cyc[$];
    logic [23:0] dv_data[$];
    int          wv_cyc[$];
    logic [95:0] wv_data[$];
    int          done_cyc[$];

    function automatic logic [23:0] pix_of(input logic [11:0] a);
        return {~a[7:0], 4'h0, a[11:8], a[7:0]};
    endfunction

    function automatic logic [95:0] wgt_of(input int i);
        logic [7:0] b;
        b = 8'(i + 1);
        return {12{b}};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_mem_en) i_mem_rdata <= amem[o_mem_addr];
        if (o_wmem_en) i_wmem_rdata <= wmem[o_wmem_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mem_en) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(o_mem_addr);
                if (!i_data_req) req_viol++;
            end
            if (o_data_val) begin
                dv_cyc.push_back(cyc);
                dv_data.push_back(o_data);
            end
            if (o_weight_val) begin
                wv_cyc.push_back(cyc);
                wv_data.push_back(o_weight);
            end
            if (o_done) done_cyc.push_back(cyc);
            if (o_data_val && o_weight_val) both_viol++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); dv_cyc.delete(); dv_data.delete();
        wv_cyc.delete(); wv_data.delete(); done_cyc.delete();
        req_viol = 0;
        both_viol = 0;
    endtask

    // pat[i] drives i_data_req in the i-th STREAM cycle; beyond plen the request stays high.
    task automatic run_job(input logic [11:0] base, input logic [31:0] npix,
                           input logic [15:0] pat, input int plen);
        clear_logs();
        @(posedge clk); #1;
        i_start = 1'b1; i_conf_base = base; i_conf_npix = npix;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 60 && done_cyc.size() == 0; k++) begin
            i_data_req = (k >= 9) ? (((k - 9) < plen) ? pat[k-9] : 1'b1) : 1'b0;
            @(posedge clk); #1;
        end
        i_data_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [11:0] base, input int npix);
        chk({tag, "_nrd"}, rd_cyc.size(), npix);
        chk({tag, "_ndv"}, dv_cyc.size(), npix);
        for (int i = 0; i < npix && i < rd_cyc.size() && i < dv_cyc.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), rd_addr[i], 12'(base + 12'(i)));
            chk($sformatf("%s_lat%0d", tag, i), dv_cyc[i], rd_cyc[i] + 1);
            chk($sformatf("%s_data%0d", tag, i), dv_data[i], pix_of(12'(base + 12'(i))));
        end
        chk({tag, "_ndone"}, done_cyc.size(), 1);
        chk({tag, "_both"}, both_viol, 0);
        chk({tag, "_busy"}, o_busy, 1'b0);
    endtask

    int offs [6] = '{0, 2, 3, 5, 6, 7};

    initial begin
        for (int a = 0; a < 4096; a++) amem[a] = pix_of(12'(a));
        for (int i = 0; i < 16; i++) wmem[i] = (i < 9) ? wgt_of(i) : 96'h0;
        rst = 1'b1; i_start = 1'b0; i_conf_base = '0; i_conf_npix = '0; i_data_req = 1'b0;
        i_mem_rdata = '0; i_wmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {o_busy, o_done, o_mem_en, o_mem_addr, o_wmem_en, o_wmem_addr,
                           o_data_val, o_weight_val, o_data, o_weight}, '0);
        rst = 1'b0;

        // base 0x010, 4 pixels, request held high; also covers the 9-beat weight load
        run_job(12'h010, 32'd4, 16'hFFFF, 16);
        chk("w_n", wv_cyc.size(), 9);
        for (int i = 0; i < 9 && i < wv_cyc.size(); i++) begin
            chk($sformatf("w_data%0d", i), wv_data[i], wgt_of(i));
            chk($sformatf("w_cyc%0d", i), wv_cyc[i], wv_cyc[0] + i);
        end
        check_stream("s4", 12'h010, 4);
        if (rd_cyc.size() == 4 && done_cyc.size() == 1)
            chk("s4_done_lat", done_cyc[0], rd_cyc[3] + 2);
        for (int i = 1; i < 4 && i < dv_cyc.size(); i++)
            chk($sformatf("s4_dv_b2b%0d", i), dv_cyc[i], dv_cyc[0] + i);

        // gated requests 1,0,1,1,0,1,1 then high
        run_job(12'h200, 32'd6, 16'b1101101, 7);
        check_stream("gate", 12'h200, 6);
        chk("gate_reqlow_rd", req_viol, 0);
        for (int i = 1; i < 6 && i < rd_cyc.size(); i++)
            chk($sformatf("gate_off%0d", i), rd_cyc[i] - rd_cyc[0], offs[i]);

        // zero pixels: weights only
        run_job(12'h050, 32'd0, 16'hFFFF, 16);
        chk("z_nw", wv_cyc.size(), 9);
        chk("z_nrd", rd_cyc.size(), 0);
        chk("z_ndone", done_cyc.size(), 1);
        chk("z_busy", o_busy, 1'b0);
        if (wv_cyc.size() == 9 && done_cyc.size() == 1)
            chk("z_done_lat", done_cyc[0], wv_cyc[8] + 1);

        // address wrap
        run_job(12'hFFE, 32'd4, 16'hFFFF, 16);
        check_stream("wrap", 12'hFFE, 4);

        // reset mid-stream, with a stray start during STREAM
        clear_logs();
        @(posedge clk); #1;
        i_start = 1'b1; i_conf_base = 12'h100; i_conf_npix = 32'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        i_data_req = 1'b1; i_start = 1'b1; i_conf_base = 12'h300; i_conf_npix = 32'd1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        i_data_req = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {o_busy, o_done, o_mem_en, o_mem_addr, o_wmem_en, o_wmem_addr,
                         o_data_val, o_weight_val, o_data, o_weight}, '0);
        rst = 1'b0;
        chk("rst_nrd", rd_addr.size(), 2);
        if (rd_addr.size() == 2) begin
            chk("rst_addr0", rd_addr[0], 12'h100);
            chk("rst_addr1", rd_addr[1], 12'h101);
        end
        clear_logs();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_quiet", rd_cyc.size() + dv_cyc.size() + wv_cyc.size() + done_cyc.size(), 0);
        chk("rst_idle", o_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
